pixel_framebuffer_sink: RTL and testbench

Terminating end of the rasterizer pixel stream (color/valid/x/y/frame_end). Writes each pixel into the back bank of a double-buffered framebuffer and swaps banks at frame end. Optionally clears the new back bank after each swap. Exposes a 1-cycle-latency read port on the front bank for display scan-out.
The stream carries no backpressure (upstream ready is tied high), so the sink accepts one pixel per cycle unconditionally.

---
 rtl/gpu_pkg.sv | 18 +
 rtl/pixel_framebuffer_sink_if.sv | 16 +
 rtl/ram_rtl.sv | 20 ++
 rtl/pixel_framebuffer_sink.sv | 129 ++++++++++++
 tb/tb_pixel_framebuffer_sink.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared pixel-path definitions used by the rasterizer and the framebuffer sink.
package gpu_pkg;
  localparam int DEF_COLOR_W = 8;
  localparam int DEF_COORD_W = 11;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    CLEAR  = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic                   valid;
    logic [DEF_COLOR_W-1:0] color;
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic                   frame_end;
  } pix_beat_t;
endpackage

// File: rtl/pixel_framebuffer_sink_if.sv
// Rasterizer pixel stream; no backpressure, so there is no ready signal.
interface pixel_framebuffer_sink_if
  import gpu_pkg::*;
#(
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int COORD_W = DEF_COORD_W
);
  logic               pix_valid;
  logic [COLOR_W-1:0] pix_color;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               pix_frame_end;

  modport master (output pix_valid, pix_color, pix_x, pix_y, pix_frame_end);
  modport slave  (input  pix_valid, pix_color, pix_x, pix_y, pix_frame_end);
endinterface

// File: rtl/ram_rtl.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module ram_rtl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_framebuffer_sink.sv
// Double-buffered framebuffer sink: pixels land in the back bank, frame_end swaps
// banks, an optional clear sweeps the new back bank, scan-out reads the front bank.
module pixel_framebuffer_sink
  import gpu_pkg::*;
#(
  parameter int                 WIDTH       = 640,
  parameter int                 HEIGHT      = 480,
  parameter int                 COLOR_W     = DEF_COLOR_W,
  parameter int                 COORD_W     = DEF_COORD_W,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
  parameter int                 ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  pixel_framebuffer_sink_if.slave  pix,
  input  logic                     clear_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [COLOR_W-1:0]       rd_data,
  output logic                     front_sel,
  output logic                     frame_done,
  output logic                     busy,
  output logic [15:0]              oob_count,
  output logic                     overrun
);
  localparam int DEPTH = WIDTH*HEIGHT;
  localparam logic [0:0] ST_ACCEPT = ACCEPT;
  localparam logic [0:0] ST_CLEAR  = CLEAR;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clearing;

  logic               s1_vld, s1_fe, s1_in_range;
  logic [COLOR_W-1:0] s1_color;
  logic [ADDR_W-1:0]  s1_addr;

  logic               drop_in, s2_drop, s2_write, s2_swap, s2_oob;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic [1:0][COLOR_W-1:0] bank_q;
  logic               rd_sel;

  assign clearing = (state == ST_CLEAR);
  assign busy     = clearing;

  // Beats arriving while clearing never enter the pipeline.
  assign drop_in = clearing && (pix.pix_valid || pix.pix_frame_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      s1_fe  <= 1'b0;
    end else begin
      s1_vld <= pix.pix_valid && !clearing;
      s1_fe  <= pix.pix_frame_end && !clearing;
    end
  end

  always_ff @(posedge clk) begin
    s1_color    <= pix.pix_color;
    s1_in_range <= (pix.pix_x < COORD_W'(WIDTH)) && (pix.pix_y < COORD_W'(HEIGHT));
    s1_addr     <= ADDR_W'(pix.pix_y) * ADDR_W'(WIDTH) + ADDR_W'(pix.pix_x);
  end

  // A beat captured on the swap edge that kicked off a clear is dropped here.
  assign s2_drop  = clearing && (s1_vld || s1_fe);
  assign s2_write = !clearing && s1_vld && s1_in_range;
  assign s2_oob   = !clearing && s1_vld && !s1_in_range;
  assign s2_swap  = !clearing && s1_fe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_ACCEPT;
      clr_cnt    <= '0;
      front_sel  <= 1'b0;
      frame_done <= 1'b0;
      oob_count  <= '0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= s2_swap;
      if (s2_swap) front_sel <= ~front_sel;
      if (s2_oob && oob_count != 16'hFFFF) oob_count <= oob_count + 16'd1;
      if (drop_in || s2_drop) overrun <= 1'b1;
      case (state)
        ST_ACCEPT: begin
          if (s2_swap && clear_en) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        default: begin
          if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= ST_ACCEPT;
          else clr_cnt <= clr_cnt + 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_en   = s2_write;
    wr_addr = s1_addr;
    wr_data = s1_color;
    if (clearing) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt;
      wr_data = CLEAR_COLOR;
    end
  end

  // Writes always target the back bank (the one not selected by front_sel).
  for (genvar b = 0; b < 2; b++) begin : g_bank
    ram_rtl #(.DATA_W(COLOR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (wr_en && (front_sel != 1'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_sel <= 1'b0;
    else          rd_sel <= front_sel;
  end

  assign rd_data = bank_q[rd_sel];
endmodule

// File: tb/tb_pixel_framebuffer_sink.sv
// Scoreboarded bench for pixel_framebuffer_sink on an 8x4 framebuffer.
module tb_pixel_framebuffer_sink;
  import gpu_pkg::*;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W*H;
  localparam int AW = $clog2(N);
  localparam logic [7:0] CC = 8'h11;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          front_sel, frame_done, busy, overrun;
  logic [15:0]   oob_count;

  pixel_framebuffer_sink_if #(.COLOR_W(8), .COORD_W(11)) pif ();

  pixel_framebuffer_sink #(
    .WIDTH(W), .HEIGHT(H), .COLOR_W(8), .COORD_W(11), .CLEAR_COLOR(CC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix        (pif),
    .clear_en   (clear_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .front_sel  (front_sel),
    .frame_done (frame_done),
    .busy       (busy),
    .oob_count  (oob_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: two banks of known contents, displayed bank, counters,
  // and the cycle window during which the sink reports busy.
  logic [7:0] mb [2][N];
  bit         kn [2][N];
  bit         mf = 1'b0;
  int         oob_m = 0;
  bit         ovr_m = 1'b0;
  bit         win_on = 1'b0;
  int         win_s = 0;
  int         exp_done[$];
  typedef struct { int cyc; logic [7:0] d; int a; } rd_t;
  rd_t        rdq[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic bit busy_at(input int c);
    return win_on && c >= win_s && c < win_s + N;
  endfunction

  function automatic pix_beat_t beat(input bit v, input int c, input int x, input int y, input bit fe);
    pix_beat_t b;
    b.valid = v; b.color = 8'(c); b.x = 11'(x); b.y = 11'(y); b.frame_end = fe;
    return b;
  endfunction

  // Monitor: busy every cycle, frame_done pulses and read data from the queues.
  always @(negedge clk) begin : mon
    rd_t r;
    if (reset_n) begin
      chk("busy", busy, busy_at(cyc));
      if (frame_done) begin
        if (exp_done.size() == 0) chk("frame_done_unexpected", frame_done, 0);
        else chk("frame_done_cycle", cyc, exp_done.pop_front());
      end else if (exp_done.size() > 0 && exp_done[0] < cyc) begin
        chk("frame_done_missing", cyc, exp_done.pop_front());
      end
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        r = rdq.pop_front();
        chk($sformatf("rd_data[%0d]", r.a), rd_data, r.d);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic model_beat(input pix_beat_t b);
    if (busy_at(cyc)) begin
      if (b.valid || b.frame_end) ovr_m = 1'b1;
      return;
    end
    if (b.valid) begin
      if (int'(b.x) < W && int'(b.y) < H) begin
        mb[!mf][int'(b.y)*W + int'(b.x)] = b.color;
        kn[!mf][int'(b.y)*W + int'(b.x)] = 1'b1;
      end else if (oob_m < 65535) begin
        oob_m++;
      end
    end
    if (b.frame_end) begin
      exp_done.push_back(cyc + 2);
      mf = !mf;
      if (clear_en) begin
        win_on = 1'b1;
        win_s  = cyc + 2;
        for (int a = 0; a < N; a++) begin
          mb[!mf][a] = CC;
          kn[!mf][a] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input pix_beat_t b);
    tick();
    pif.pix_valid     = b.valid;
    pif.pix_color     = b.color;
    pif.pix_x         = b.x;
    pif.pix_y         = b.y;
    pif.pix_frame_end = b.frame_end;
    model_beat(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(beat(0, 0, 0, 0, 0));
  endtask

  task automatic rd(input int a);
    drive(beat(0, 0, 0, 0, 0));
    rd_addr = AW'(a);
    if (kn[mf][a]) rdq.push_back('{cyc + 1, mb[mf][a], a});
  endtask

  task automatic read_all();
    for (int a = 0; a < N; a++) rd(a);
    idle(2);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".front_sel"}, front_sel, mf);
    chk({tag, ".oob_count"}, oob_count, oob_m);
    chk({tag, ".overrun"}, overrun, ovr_m);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      idle(1);
      n++;
    end
    chk({tag, ".busy_timeout"}, n < 200, 1);
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int np;
    pif.pix_valid = 1'b0; pif.pix_color = '0; pif.pix_x = '0; pif.pix_y = '0;
    pif.pix_frame_end = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.front_sel", front_sel, 0);
    chk("rst.frame_done", frame_done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.oob_count", oob_count, 0);
    chk("rst.overrun", overrun, 0);
    reset_n = 1'b1;

    // Single pixel then an empty frame_end
    drive(beat(1, 8'h5A, 3, 2, 0));
    drive(beat(0, 0, 0, 0, 1));
    idle(2);
    chk("t1.front_sel", front_sel, 1);
    chk_status("t1");
    rd(19);
    idle(2);

    // Out-of-range pixels are counted and never written
    drive(beat(1, 8'h33, 8, 0, 0));
    drive(beat(1, 8'h44, 0, 4, 0));
    idle(2);
    chk("t2.oob_count", oob_count, 2);
    chk_status("t2");

    // Last pixel carries frame_end
    drive(beat(1, 8'hFF, 7, 3, 1));
    idle(2);
    chk_status("t3");
    rd(31);
    idle(2);

    // Swap with clear, then traffic during busy
    clear_en = 1'b1;
    drive(beat(0, 0, 0, 0, 1));
    idle(2);
    clear_en = 1'b0;
    idle(5);
    drive(beat(1, 8'hAB, 2, 1, 0));
    drive(beat(0, 0, 0, 0, 1));
    idle(1);
    wait_idle("t4");
    idle(1);
    chk("t5.overrun", overrun, 1);
    chk_status("t5");
    drive(beat(0, 0, 0, 0, 1));
    idle(2);
    chk_status("t4b");
    read_all();

    // Random frames
    for (int f = 0; f < 6; f++) begin
      np = $urandom_range(40, 5);
      for (int i = 0; i < np; i++)
        drive(beat(($urandom % 4) != 0, $urandom % 256, $urandom_range(9, 0),
                   $urandom_range(5, 0), (i == np - 1) && ($urandom % 2 == 1)));
      drive(beat(0, 0, 0, 0, 1));
      idle(2);
      if (exp_done.size() == 0) chk_status($sformatf("rnd%0d", f));
      idle(2);
      chk_status($sformatf("rnd%0d", f));
      read_all();
    end

    // Reset in the middle of a clear
    clear_en = 1'b1;
    drive(beat(0, 0, 0, 0, 1));
    idle(2);
    clear_en = 1'b0;
    idle(9);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t6.busy", busy, 0);
    chk("t6.front_sel", front_sel, 0);
    chk("t6.overrun", overrun, 0);
    chk("t6.oob_count", oob_count, 0);
    chk("t6.frame_done", frame_done, 0);
    for (int a = 0; a < N; a++) kn[!mf][a] = 1'b0;
    mf = 1'b0; oob_m = 0; ovr_m = 1'b0; win_on = 1'b0;
    exp_done.delete();
    rdq.delete();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++)
      drive(beat(1, $urandom % 256, $urandom_range(7, 0), $urandom_range(3, 0), 0));
    drive(beat(0, 0, 0, 0, 1));
    idle(2);
    chk_status("t6b");
    read_all();

    idle(3);
    chk("end.frame_done_queue", exp_done.size(), 0);
    chk("end.read_queue", rdq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
